// File: rtl/gfx_transform_feeder.sv
// Point FIFO plus issue/ack/draw sequencer in front of the transform unit.
// Optional GFX_FEEDER_STRIP_EN adds strip_i for triangle-strip slot reuse.
module gfx_transform_feeder #(
  parameter int point_width    = 16,
  parameter int subpixel_width = 16,
  parameter int fifo_depth     = 4
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic signed [point_width+subpixel_width-1:0]     pt_x_i,
  input  logic signed [point_width+subpixel_width-1:0]     pt_y_i,
  input  logic signed [point_width+subpixel_width-1:0]     pt_z_i,
  input  logic                                             pt_valid_i,
  output logic                                             pt_ready_o,
  input  logic                                             transform_en_i,
  input  logic [1:0]                                       prim_i,
`ifdef GFX_FEEDER_STRIP_EN
  input  logic                                             strip_i,
`endif
  input  logic                                             flush_i,
  output logic signed [point_width+subpixel_width-1:0]     x_o,
  output logic signed [point_width+subpixel_width-1:0]     y_o,
  output logic signed [point_width+subpixel_width-1:0]     z_o,
  output logic [1:0]                                       point_id_o,
  output logic                                             transform_o,
  output logic                                             forward_o,
  input  logic                                             ack_i,
  output logic                                             draw_o,
  input  logic                                             draw_ack_i,
  output logic                                             busy_o
);

  localparam int CW = point_width + subpixel_width;
  localparam int AW = $clog2(fifo_depth);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DRAW, WAIT_DRAW} state_t;

  state_t state, state_nxt;

  logic signed [CW-1:0] mem_x [fifo_depth];
  logic signed [CW-1:0] mem_y [fifo_depth];
  logic signed [CW-1:0] mem_z [fifo_depth];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;

  logic [1:0] pt_cnt;
  logic [1:0] last_idx;
  logic [1:0] slot;
  logic       mode;
  logic       abort;
  logic       last_pt;

`ifdef GFX_FEEDER_STRIP_EN
  logic       strip_act;
  logic [1:0] slot_q;

  function automatic logic [1:0] sat_inc3(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] wrap_inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign slot    = slot_q;
  assign last_pt = strip_act ? (pt_cnt >= 2'd2) : (pt_cnt == last_idx);
`else
  assign slot    = pt_cnt;
  assign last_pt = (pt_cnt == last_idx);
`endif

  // Ready uses the pre-pop full flag, so a push is refused on a full FIFO
  // even when a pop happens in the same cycle.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign pt_ready_o = !full && !flush_i && !rst_i;
  assign push       = pt_valid_i && pt_ready_o;
  assign pop        = (state == IDLE) && !empty && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_x[wr_ptr[AW-1:0]] <= pt_x_i;
      mem_y[wr_ptr[AW-1:0]] <= pt_y_i;
      mem_z[wr_ptr[AW-1:0]] <= pt_z_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pop) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK:  if (ack_i) state_nxt = (abort || flush_i || !last_pt) ? IDLE : DRAW;
      DRAW:      state_nxt = WAIT_DRAW;
      WAIT_DRAW: if (draw_ack_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    transform_o = (state == ISSUE) && mode;
    forward_o   = (state == ISSUE) && !mode;
    draw_o      = (state == DRAW);
    busy_o      = (state != IDLE) || !empty;
  end

  // Primitive bookkeeping; mode and size are captured only on a primitive's first pop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pt_cnt   <= '0;
      last_idx <= '0;
      mode     <= 1'b0;
      abort    <= 1'b0;
`ifdef GFX_FEEDER_STRIP_EN
      strip_act <= 1'b0;
      slot_q    <= '0;
`endif
    end else begin
      if (pop && pt_cnt == 2'd0) begin
        mode     <= transform_en_i;
        last_idx <= {prim_i[1], prim_i[0] & ~prim_i[1]};
`ifdef GFX_FEEDER_STRIP_EN
        strip_act <= strip_i && prim_i[1];
`endif
      end
      if (flush_i) begin
        pt_cnt <= '0;
        abort  <= (state == ISSUE) || (state == WAIT_ACK && !ack_i);
`ifdef GFX_FEEDER_STRIP_EN
        slot_q <= '0;
`endif
      end else if (state == WAIT_ACK && ack_i) begin
        abort <= 1'b0;
        if (abort) begin
          pt_cnt <= '0;
`ifdef GFX_FEEDER_STRIP_EN
          slot_q <= '0;
        end else if (strip_act) begin
          pt_cnt <= sat_inc3(pt_cnt);
          slot_q <= wrap_inc3(slot_q);
        end else if (last_pt) begin
          pt_cnt <= '0;
          slot_q <= '0;
        end else begin
          pt_cnt <= pt_cnt + 2'd1;
          slot_q <= slot_q + 2'd1;
        end
`else
        end else if (last_pt) begin
          pt_cnt <= '0;
        end else begin
          pt_cnt <= pt_cnt + 2'd1;
        end
`endif
      end
    end
  end

  // Issue registers: loaded on pop and held through WAIT_ACK
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_o        <= '0;
      y_o        <= '0;
      z_o        <= '0;
      point_id_o <= '0;
    end else if (pop) begin
      x_o        <= mem_x[rd_ptr[AW-1:0]];
      y_o        <= mem_y[rd_ptr[AW-1:0]];
      z_o        <= mem_z[rd_ptr[AW-1:0]];
      point_id_o <= slot;
    end
  end

endmodule
